// File: rtl/sort_mem_responder_if.sv
// Bus bundle between the sort datapath / host and the sort memory responder.
// The stats counters exist only when SORT_MEM_STATS_EN is defined.
interface sort_mem_responder_if #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 4
);
    // sort engine side
    logic                 sort_go;
    logic                 sort_done;
    logic                 ren;
    logic                 wen;
    logic [ADDRWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0] wdata;
    logic [DATAWIDTH-1:0] rdata;
    logic                 rvalid;

    // host load / readback side
    logic                 h_req;
    logic                 h_we;
    logic [ADDRWIDTH-1:0] h_addr;
    logic [DATAWIDTH-1:0] h_wdata;
    logic [DATAWIDTH-1:0] h_rdata;
    logic                 h_ack;

    logic                 busy;

`ifdef SORT_MEM_STATS_EN
    logic [15:0]          rd_count;
    logic [15:0]          wr_count;
`endif

    // requester side: sort engine plus host
    modport master (
        output sort_go, sort_done, ren, wen, addr, wdata,
        output h_req, h_we, h_addr, h_wdata,
`ifdef SORT_MEM_STATS_EN
        input  rd_count, wr_count,
`endif
        input  rdata, rvalid, h_rdata, h_ack, busy
    );

    // responder side: the memory
    modport slave (
        input  sort_go, sort_done, ren, wen, addr, wdata,
        input  h_req, h_we, h_addr, h_wdata,
`ifdef SORT_MEM_STATS_EN
        output rd_count, wr_count,
`endif
        output rdata, rvalid, h_rdata, h_ack, busy
    );
endinterface

// File: rtl/sort_mem_responder.sv
// Memory-side responder for the sort datapath.
// An arbiter FSM gives the element array either to the sort engine
// (one ren/wen access per cycle) or to the host (one load/readback
// access per request, acknowledged with a one-cycle h_ack pulse).
// Optional feature macro: SORT_MEM_STATS_EN adds saturating
// rd_count/wr_count counters of sort-side accesses.
module sort_mem_responder #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ADDRWIDTH = 4,
    parameter int unsigned DEPTH     = 16
) (
    input logic                 c_clk,
    input logic                 rst,
    sort_mem_responder_if.slave bus
);

    localparam int unsigned CNTWIDTH = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SORT,
        S_HOST,
        S_ACK
    } state_t;

    state_t               state;
    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic                 sort_in_range_c;
    logic                 host_in_range_c;
    logic                 sort_rd_c;
    logic                 sort_wr_c;
    logic                 host_wr_c;
    logic [DATAWIDTH-1:0] sort_mem_rd_c;
    logic [DATAWIDTH-1:0] host_mem_rd_c;

    // Decode which accesses are live this cycle; out-of-range reads return 0.
    always_comb begin
        sort_in_range_c = 1'b0;
        host_in_range_c = 1'b0;
        sort_rd_c       = 1'b0;
        sort_wr_c       = 1'b0;
        host_wr_c       = 1'b0;
        sort_mem_rd_c   = '0;
        host_mem_rd_c   = '0;

        sort_in_range_c = (32'(bus.addr) < DEPTH);
        host_in_range_c = (32'(bus.h_addr) < DEPTH);

        if (sort_in_range_c) begin
            sort_mem_rd_c = mem[bus.addr];
        end
        if (host_in_range_c) begin
            host_mem_rd_c = mem[bus.h_addr];
        end

        sort_rd_c = (state == S_SORT) && bus.ren;
        sort_wr_c = (state == S_SORT) && bus.wen && sort_in_range_c;
        host_wr_c = (state == S_HOST) && bus.h_we && host_in_range_c;
    end

    // Element array: contents survive reset; only the owner may write.
    always_ff @(posedge c_clk) begin
        if (sort_wr_c) begin
            mem[bus.addr] <= bus.wdata;
        end
        if (host_wr_c) begin
            mem[bus.h_addr] <= bus.h_wdata;
        end
    end

    // Arbiter FSM with registered sort/host responses.
    always_ff @(posedge c_clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            bus.rdata   <= '0;
            bus.rvalid  <= 1'b0;
            bus.h_rdata <= '0;
            bus.h_ack   <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.rvalid <= sort_rd_c;
            bus.h_ack  <= 1'b0;
            if (sort_rd_c) begin
                // read-before-write: the array still holds the old word here
                bus.rdata <= sort_mem_rd_c;
            end

            case (state)
                S_IDLE: begin
                    // sort has priority; a simultaneous host request waits
                    if (bus.sort_go) begin
                        state    <= S_SORT;
                        bus.busy <= 1'b1;
                    end else if (bus.h_req) begin
                        state    <= S_HOST;
                        bus.busy <= 1'b1;
                    end
                end
                S_SORT: begin
                    if (bus.sort_done) begin
                        state    <= S_IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                S_HOST: begin
                    if (!bus.h_we) begin
                        bus.h_rdata <= host_mem_rd_c;
                    end
                    state     <= S_ACK;
                    bus.h_ack <= 1'b1;
                end
                S_ACK: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef SORT_MEM_STATS_EN
    localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

    // Saturating access counters, cleared when a new sort takes the array.
    always_ff @(posedge c_clk or posedge rst) begin
        if (rst) begin
            bus.rd_count <= '0;
            bus.wr_count <= '0;
        end else if ((state == S_IDLE) && bus.sort_go) begin
            bus.rd_count <= '0;
            bus.wr_count <= '0;
        end else if (state == S_SORT) begin
            if (bus.ren && (bus.rd_count != CNT_MAX)) begin
                bus.rd_count <= bus.rd_count + CNTWIDTH'(1);
            end
            if (bus.wen && (bus.wr_count != CNT_MAX)) begin
                bus.wr_count <= bus.wr_count + CNTWIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_sort_mem_responder.sv
// Self-checking bench for sort_mem_responder: directed scenarios followed by
// randomized host/sort traffic against a transaction-level array model.
// DEPTH is set below 2**ADDRWIDTH so out-of-range addresses are exercised.
module tb_sort_mem_responder;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 4;
    localparam int unsigned DEP = 12;

    logic c_clk;
    logic rst;

    sort_mem_responder_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) bus ();

    sort_mem_responder #(
        .DATAWIDTH(DW),
        .ADDRWIDTH(AW),
        .DEPTH    (DEP)
    ) dut (
        .c_clk(c_clk),
        .rst  (rst),
        .bus  (bus)
    );

    initial c_clk = 1'b0;
    always #5 c_clk = ~c_clk;

    // reference model state
    logic [DW-1:0] mdl_mem [16];
    logic [DW-1:0] mdl_rdata;
    logic [DW-1:0] mdl_hrdata;
    bit            in_sort;
    int            mdl_rd_n;
    int            mdl_wr_n;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
        return (int'(a) < int'(DEP)) ? mdl_mem[a] : '0;
    endfunction

    // One sort-port cycle: drive, advance to the next negedge, check the response.
    task automatic sort_cyc(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit exp_rv;
        bus.ren   = r;
        bus.wen   = w;
        bus.addr  = a;
        bus.wdata = d;
        exp_rv = in_sort && r;
        if (exp_rv) mdl_rdata = mdl_read(a);
        if (in_sort && w && (int'(a) < int'(DEP))) mdl_mem[a] = d;
        if (in_sort && r) mdl_rd_n++;
        if (in_sort && w) mdl_wr_n++;
        @(negedge c_clk);
        bus.ren = 1'b0;
        bus.wen = 1'b0;
        chk("rvalid", 64'(bus.rvalid), 64'(exp_rv));
        chk("rdata", 64'(bus.rdata), 64'(mdl_rdata));
    endtask

    task automatic check_stats();
`ifdef SORT_MEM_STATS_EN
        chk("rd_count", 64'(bus.rd_count), 64'(mdl_rd_n));
        chk("wr_count", 64'(bus.wr_count), 64'(mdl_wr_n));
`endif
    endtask

    task automatic start_sort();
        bus.sort_go = 1'b1;
        @(negedge c_clk);
        bus.sort_go = 1'b0;
        in_sort  = 1'b1;
        mdl_rd_n = 0;
        mdl_wr_n = 0;
        chk("busy_sort", 64'(bus.busy), 64'd1);
        chk("rvalid_start", 64'(bus.rvalid), 64'd0);
        check_stats();
    endtask

    task automatic end_sort();
        bus.sort_done = 1'b1;
        sort_cyc(1'b0, 1'b0, '0, '0);
        bus.sort_done = 1'b0;
        in_sort = 1'b0;
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        check_stats();
    endtask

    task automatic host_drive(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.h_req   = 1'b1;
        bus.h_we    = we;
        bus.h_addr  = a;
        bus.h_wdata = d;
    endtask

    // Wait for the ack (bounded), check latency/data, then drop the request.
    task automatic host_finish(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int cyc;
        cyc = 0;
        do begin
            @(negedge c_clk);
            cyc++;
        end while (!bus.h_ack && cyc < 8);
        chk("ack_latency", 64'(cyc), 64'd2);
        if (we) begin
            if (int'(a) < int'(DEP)) mdl_mem[a] = d;
        end else begin
            mdl_hrdata = mdl_read(a);
        end
        chk("h_rdata", 64'(bus.h_rdata), 64'(mdl_hrdata));
        bus.h_req = 1'b0;
        @(negedge c_clk);
        chk("ack_pulse", 64'(bus.h_ack), 64'd0);
        chk("busy_idle", 64'(bus.busy), 64'd0);
    endtask

    task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_drive(we, a, d);
        host_finish(we, a, d);
    endtask

    logic [DW-1:0] init_vals [16];

    initial begin
        n_vec = 0;
        n_err = 0;
        init_vals = '{32'd9, 32'd3, 32'd7, 32'd3, 32'd4, 32'h11, 32'd0, 32'd14,
                      32'd2, 32'd11, 32'd6, 32'd13, 32'd1, 32'd10, 32'd8, 32'd15};
        for (int i = 0; i < 16; i++) mdl_mem[i] = 'x;
        mdl_rdata  = '0;
        mdl_hrdata = '0;
        in_sort    = 1'b0;
        mdl_rd_n   = 0;
        mdl_wr_n   = 0;

        bus.sort_go = 0; bus.sort_done = 0; bus.ren = 0; bus.wen = 0;
        bus.addr = '0; bus.wdata = '0;
        bus.h_req = 0; bus.h_we = 0; bus.h_addr = '0; bus.h_wdata = '0;

        // reset state
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_h_ack", 64'(bus.h_ack), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        chk("rst_h_rdata", 64'(bus.h_rdata), 64'd0);
        @(negedge c_clk);
        @(negedge c_clk);
        rst = 1'b0;
        @(negedge c_clk);

        // host fill of every address (12..15 are out of range and dropped), then readback
        for (int i = 0; i < 16; i++) host_op(1'b1, AW'(i), init_vals[i]);
        for (int i = 0; i < 16; i++) host_op(1'b0, AW'(i), '0);

        // back-to-back sort reads of addr 2 then 3
        start_sort();
        sort_cyc(1'b1, 1'b0, 4'd2, '0);
        sort_cyc(1'b1, 1'b0, 4'd3, '0);
        sort_cyc(1'b0, 1'b0, 4'd3, '0);

        // same-cycle read and write of addr 5 returns the old word, then the new one
        sort_cyc(1'b1, 1'b1, 4'd5, 32'hAA);
        sort_cyc(1'b1, 1'b0, 4'd5, '0);
        // out-of-range sort write is dropped and out-of-range read returns 0
        sort_cyc(1'b0, 1'b1, 4'd13, 32'hBEEF);
        sort_cyc(1'b1, 1'b0, 4'd13, '0);
        end_sort();

        // host read after the sort confirms the array content
        host_op(1'b0, 4'd5, '0);

        // sort_go and h_req together: sort wins, host completes after sort_done
        host_drive(1'b1, 4'd6, 32'h66);
        bus.sort_go = 1'b1;
        @(negedge c_clk);
        bus.sort_go = 1'b0;
        in_sort  = 1'b1;
        mdl_rd_n = 0;
        mdl_wr_n = 0;
        chk("sim_busy", 64'(bus.busy), 64'd1);
        chk("sim_no_ack", 64'(bus.h_ack), 64'd0);
        sort_cyc(1'b1, 1'b0, 4'd6, '0);
        chk("sim_no_ack2", 64'(bus.h_ack), 64'd0);
        sort_cyc(1'b0, 1'b0, 4'd0, '0);
        end_sort();
        host_finish(1'b1, 4'd6, 32'h66);

        // sort-port traffic with no sort running is ignored
        sort_cyc(1'b1, 1'b1, 4'd4, 32'h55);
        host_op(1'b0, 4'd4, '0);

        // reset in S_HOST abandons the write and clears outputs at once
        host_drive(1'b1, 4'd1, 32'hDEAD);
        @(negedge c_clk);
        chk("host_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        mdl_rdata  = '0;
        mdl_hrdata = '0;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_h_ack", 64'(bus.h_ack), 64'd0);
        chk("mid_rst_rdata", 64'(bus.rdata), 64'd0);
        chk("mid_rst_rvalid", 64'(bus.rvalid), 64'd0);
        bus.h_req = 1'b0;
        @(negedge c_clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge c_clk);
            chk("no_ack_after_rst", 64'(bus.h_ack), 64'd0);
        end
        host_op(1'b0, 4'd1, '0);
        host_op(1'b0, 4'd2, '0);

        // stats scenario: 6 reads, 2 writes, then next sort clears the counters
        start_sort();
        for (int i = 0; i < 6; i++) sort_cyc(1'b1, (i < 2), AW'(i), DW'(32'h100 + i));
        end_sort();
        start_sort();
        end_sort();

        // randomized traffic
        for (int it = 0; it < 150; it++) begin
            int op;
            op = int'($urandom_range(0, 3));
            case (op)
                0: host_op(1'b1, AW'($urandom), DW'($urandom));
                1: host_op(1'b0, AW'($urandom), '0);
                2: begin
                    int len;
                    len = int'($urandom_range(1, 8));
                    start_sort();
                    for (int k = 0; k < len; k++)
                        sort_cyc(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
                    end_sort();
                end
                default: sort_cyc(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom));
            endcase
        end

        // final full readback
        for (int i = 0; i < 16; i++) host_op(1'b0, AW'(i), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
